conv_mem_arb: RTL and testbench
===============================

CONV_MEM_ARB -- requirements
Module: conv_mem_arb

Interface
REQ-001 SHALL have no parameters; widths fixed: address 12 bits, data 20 bits, L0 frame 4096 words.
REQ-002 SHALL have port: clk  in  1  sole clock, all state changes on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  in  1  one-cycle pulse that begins a frame.
REQ-005 SHALL have port: busy  out  1  frame in progress.
REQ-006 SHALL have ports: c_req in 1, c_addr in 12, c_wdata in 20, c_ack out 1  conv engine L0 write requester.
REQ-007 SHALL have ports: p_req in 1, p_we in 1, p_sel in 1 (0=L0, 1=L1), p_addr in 12, p_wdata in 20, p_ack out 1  pooling engine requester.
REQ-008 SHALL have ports: p_rdata out 20, p_rvalid out 1  read return to the pooling engine.
REQ-009 SHALL have port: p_done  in  1  pooling engine finished its last access.
REQ-010 SHALL have ports: cwr out 1, crd out 1, csel out 3, caddr_wr out 12, caddr_rd out 12, cdata_wr out 20, cdata_rd in 20  shared memory port.
REQ-011 SHALL have port: wr_count  out  13  number of conv writes granted this frame.

Function
REQ-012 SHALL set busy on the edge sampling start=1 while busy=0, and clear wr_count to 0 on that same edge; start while busy=1 is ignored.
REQ-013 SHALL clear busy on the edge sampling p_done=1 while wr_count=4096; p_done at any other time is ignored.
REQ-014 SHALL compute c_ack and p_ack combinationally in the current cycle; at most one is high per cycle; both are 0 while busy=0.
REQ-015 SHALL treat the pooling request as eligible only if p_req=1 and NOT (p_we=0, p_sel=0, p_addr >= wr_count); L1 accesses and L0 writes are never hazard-blocked.
REQ-016 SHALL grant the sole eligible requester; when both are eligible, SHALL grant the requester not granted most recently (round-robin, 1-bit last pointer updated on every grant).
REQ-017 SHALL increment wr_count on each edge where c_ack=1; wr_count saturates at 4096.
REQ-018 SHALL register the granted access onto the memory port for exactly the cycle after the ack: conv -> cwr=1, csel=001, caddr_wr=c_addr, cdata_wr=c_wdata.
REQ-019 Pool write -> cwr=1, csel=001/011 per p_sel=0/1, caddr_wr=p_addr, cdata_wr=p_wdata; pool read -> crd=1, same csel mapping, caddr_rd=p_addr.
REQ-020 SHALL drive cwr=0, crd=0, csel=000 in any cycle following no grant; caddr_*/cdata_wr hold their last values.
REQ-021 SHALL capture cdata_rd into p_rdata at the end of the crd=1 cycle and pulse p_rvalid=1 for the following single cycle (read latency: ack in cycle T, crd in T+1, p_rvalid in T+2); p_rdata holds until the next read return.
REQ-022 Requesters hold req and payload stable until the cycle their ack is 1 and may present a new request on the next cycle; back-to-back grants SHALL sustain one access per cycle.
REQ-023 SHALL give conv the grant in a tie when the pooling request is hazard-blocked (blocked pool never counts as requesting, so conv cannot be starved by it).

Reset
REQ-024 On reset=0, SHALL immediately force busy=0, c_ack=0, p_ack=0, cwr=0, crd=0, csel=000, p_rvalid=0, p_rdata=0, caddr_wr=0, caddr_rd=0, cdata_wr=0, wr_count=0, last pointer = pool (so the first tie goes to conv).
REQ-025 Reset asserted mid-frame SHALL abandon any in-flight port cycle and pending p_rvalid with no further memory activity until a new start after reset release.

Verification
REQ-026 Start, conv writes addr 0..3 with data 0x00010..0x00013, no pool requests -> c_ack 4 consecutive cycles, cwr=1/csel=001 on the following 4 cycles, wr_count=4.
REQ-027 wr_count=5, pool read L0 addr 5 with c_req=0 -> p_ack stays 0; conv then writes addr 5 -> p_ack next cycle, crd=1 csel=001 caddr_rd=5, p_rvalid two cycles after p_ack with the written data.
REQ-028 Both requesting continuously (pool writing L1 addr 0x010) -> grants alternate conv, pool, conv, pool; first tie after reset goes to conv; pool writes show csel=011.
REQ-029 Conv completes 4096 writes -> wr_count=4096 holds through a further c_req; p_done pulse -> busy=0 next edge; p_done earlier (wr_count=4000) -> busy stays 1.
REQ-030 Assert reset=0 in the cycle a pool read is acked -> crd, p_rvalid never rise, busy=0, wr_count=0 immediately; start after release restarts cleanly.
REQ-031 Start pulse while busy=1 at wr_count=100 -> wr_count stays 100, busy stays 1.

Source files
------------

// File: rtl/conv_mem_arb.sv
// conv_mem_arb
// Arbitrates one shared memory port between a conv engine (L0 writes only)
// and a pooling engine (L0/L1 reads and writes) for the duration of a frame.
// Within a frame, a pooling read of an L0 word is held off until the conv
// engine has written past that address.
//
// Ports
//   clk, reset          : clock (rising edge), asynchronous active-low reset
//   start, busy         : frame start pulse, frame-in-progress flag
//   c_req/c_addr/c_wdata/c_ack : conv engine L0 write requester
//   p_req/p_we/p_sel/p_addr/p_wdata/p_ack : pooling requester (p_sel 0=L0, 1=L1)
//   p_rdata/p_rvalid    : read return to the pooling engine (two cycles after ack)
//   p_done              : pooling engine finished; ends the frame once L0 is full
//   cwr/crd/csel/caddr_wr/caddr_rd/cdata_wr/cdata_rd : shared memory port,
//                         driven in the cycle after the corresponding ack
//   wr_count            : conv writes granted this frame (saturates at 4096)
module conv_mem_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  input  logic        c_req,
  input  logic [11:0] c_addr,
  input  logic [19:0] c_wdata,
  output logic        c_ack,
  input  logic        p_req,
  input  logic        p_we,
  input  logic        p_sel,
  input  logic [11:0] p_addr,
  input  logic [19:0] p_wdata,
  output logic        p_ack,
  output logic [19:0] p_rdata,
  output logic        p_rvalid,
  input  logic        p_done,
  output logic        cwr,
  output logic        crd,
  output logic [2:0]  csel,
  output logic [11:0] caddr_wr,
  output logic [11:0] caddr_rd,
  output logic [19:0] cdata_wr,
  input  logic [19:0] cdata_rd,
  output logic [12:0] wr_count
);

  localparam logic [12:0] FRAME_WORDS = 13'd4096;
  localparam logic [2:0]  SEL_NONE    = 3'b000;
  localparam logic [2:0]  SEL_L0      = 3'b001;
  localparam logic [2:0]  SEL_L1      = 3'b011;

  // Frame state
  logic        busy_q,      busy_d;
  logic [12:0] wr_count_q,  wr_count_d;
  logic        last_pool_q, last_pool_d;  // 1: pool won the most recent grant

  // Registered memory port
  logic        cwr_q,      cwr_d;
  logic        crd_q,      crd_d;
  logic [2:0]  csel_q,     csel_d;
  logic [11:0] caddr_wr_q, caddr_wr_d;
  logic [11:0] caddr_rd_q, caddr_rd_d;
  logic [19:0] cdata_wr_q, cdata_wr_d;

  // Read return
  logic [19:0] p_rdata_q,  p_rdata_d;
  logic        p_rvalid_q, p_rvalid_d;

  // Arbitration
  logic c_elig_s;
  logic p_hazard_s;
  logic p_elig_s;
  logic c_grant_s;
  logic p_grant_s;

  // Eligibility and round-robin grant selection for the current cycle.
  always_comb begin
    c_elig_s   = busy_q & c_req;
    // An L0 read of a word the conv engine has not yet written this frame
    // must wait; a blocked pool request does not compete at all.
    p_hazard_s = ~p_we & ~p_sel & ({1'b0, p_addr} >= wr_count_q);
    p_elig_s   = busy_q & p_req & ~p_hazard_s;
    if (c_elig_s && p_elig_s) begin
      c_grant_s = last_pool_q;
      p_grant_s = ~last_pool_q;
    end else begin
      c_grant_s = c_elig_s;
      p_grant_s = p_elig_s;
    end
  end

  // Next frame state: start, write counting, completion and the RR pointer.
  always_comb begin
    busy_d      = busy_q;
    wr_count_d  = wr_count_q;
    last_pool_d = last_pool_q;
    if (!busy_q) begin
      if (start) begin
        busy_d     = 1'b1;
        wr_count_d = 13'd0;
      end else begin
        busy_d     = 1'b0;
      end
    end else begin
      if (c_grant_s && (wr_count_q != FRAME_WORDS)) begin
        wr_count_d = wr_count_q + 13'd1;
      end else begin
        wr_count_d = wr_count_q;
      end
      if (p_done && (wr_count_q == FRAME_WORDS)) begin
        busy_d = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end
    if (c_grant_s) begin
      last_pool_d = 1'b0;
    end else if (p_grant_s) begin
      last_pool_d = 1'b1;
    end else begin
      last_pool_d = last_pool_q;
    end
  end

  // Next memory-port cycle; addresses and write data hold when idle.
  always_comb begin
    cwr_d      = 1'b0;
    crd_d      = 1'b0;
    csel_d     = SEL_NONE;
    caddr_wr_d = caddr_wr_q;
    caddr_rd_d = caddr_rd_q;
    cdata_wr_d = cdata_wr_q;
    if (c_grant_s) begin
      cwr_d      = 1'b1;
      csel_d     = SEL_L0;
      caddr_wr_d = c_addr;
      cdata_wr_d = c_wdata;
    end else if (p_grant_s) begin
      csel_d = p_sel ? SEL_L1 : SEL_L0;
      if (p_we) begin
        cwr_d      = 1'b1;
        caddr_wr_d = p_addr;
        cdata_wr_d = p_wdata;
      end else begin
        crd_d      = 1'b1;
        caddr_rd_d = p_addr;
      end
    end else begin
      cwr_d = 1'b0;
    end
  end

  // Read return: capture memory data at the end of the read cycle.
  always_comb begin
    p_rvalid_d = crd_q;
    if (crd_q) begin
      p_rdata_d = cdata_rd;
    end else begin
      p_rdata_d = p_rdata_q;
    end
  end

  // State registers; reset abandons any in-flight port cycle or read return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q      <= 1'b0;
      wr_count_q  <= 13'd0;
      last_pool_q <= 1'b1;
      cwr_q       <= 1'b0;
      crd_q       <= 1'b0;
      csel_q      <= SEL_NONE;
      caddr_wr_q  <= 12'd0;
      caddr_rd_q  <= 12'd0;
      cdata_wr_q  <= 20'd0;
      p_rdata_q   <= 20'd0;
      p_rvalid_q  <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      wr_count_q  <= wr_count_d;
      last_pool_q <= last_pool_d;
      cwr_q       <= cwr_d;
      crd_q       <= crd_d;
      csel_q      <= csel_d;
      caddr_wr_q  <= caddr_wr_d;
      caddr_rd_q  <= caddr_rd_d;
      cdata_wr_q  <= cdata_wr_d;
      p_rdata_q   <= p_rdata_d;
      p_rvalid_q  <= p_rvalid_d;
    end
  end

  assign busy     = busy_q;
  assign wr_count = wr_count_q;
  assign c_ack    = c_grant_s;
  assign p_ack    = p_grant_s;
  assign cwr      = cwr_q;
  assign crd      = crd_q;
  assign csel     = csel_q;
  assign caddr_wr = caddr_wr_q;
  assign caddr_rd = caddr_rd_q;
  assign cdata_wr = cdata_wr_q;
  assign p_rdata  = p_rdata_q;
  assign p_rvalid = p_rvalid_q;

endmodule

// File: tb/tb_conv_mem_arb.sv
// Testbench for conv_mem_arb: reference model predicts acks and frame state
// each cycle and queues the expected memory-port cycle and read return; a
// separate monitor pops and compares whenever the DUT presents them.
module tb_conv_mem_arb;

  logic        clk, reset, start, busy;
  logic        c_req, c_ack, p_req, p_we, p_sel, p_ack, p_rvalid, p_done;
  logic        cwr, crd;
  logic [11:0] c_addr, p_addr, caddr_wr, caddr_rd;
  logic [19:0] c_wdata, p_wdata, p_rdata, cdata_wr, cdata_rd;
  logic [2:0]  csel;
  logic [12:0] wr_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          stamp;
    bit          wr;
    bit          rd;
    logic [2:0]  sel;
    logic [11:0] addr;
    logic [19:0] data;
  } port_t;
  typedef struct {
    int          due;
    logic [19:0] data;
  } rd_t;

  port_t port_q[$];
  rd_t   rd_q[$];

  // Reference model state
  int          m_busy;
  int          m_wc;
  bit          m_last_pool;
  logic [19:0] exp_mem [0:1][0:4095];
  logic [19:0] exp_last_rdata;

  // Memory responder behind the DUT port
  logic [19:0] resp_mem [0:1][0:4095];
  bit          resp_wr  [0:1][0:4095];

  bit c_got, p_got;

  conv_mem_arb dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack),
    .p_req(p_req), .p_we(p_we), .p_sel(p_sel), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_ack(p_ack), .p_rdata(p_rdata), .p_rvalid(p_rvalid),
    .p_done(p_done), .cwr(cwr), .crd(crd), .csel(csel),
    .caddr_wr(caddr_wr), .caddr_rd(caddr_rd), .cdata_wr(cdata_wr),
    .cdata_rd(cdata_rd), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [19:0] init_word(input logic s, input logic [11:0] a);
    return {7'h00, s, a} ^ 20'h53C00;
  endfunction

  assign cdata_rd = resp_wr[csel[1]][caddr_rd] ? resp_mem[csel[1]][caddr_rd]
                                               : init_word(csel[1], caddr_rd);

  always @(posedge clk) begin
    if (cwr) begin
      resp_mem[csel[1]][caddr_wr] <= cdata_wr;
      resp_wr[csel[1]][caddr_wr]  <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one evaluation per cycle at the falling edge.
  always @(negedge clk) begin : model
    bit    ce, pe, gc, gp;
    int    wc0;
    port_t e;
    if (!reset) begin
      m_busy      = 0;
      m_wc        = 0;
      m_last_pool = 1'b1;
      check("rst_busy", 32'(busy), 0);
      check("rst_wr_count", 32'(wr_count), 0);
      check("rst_c_ack", 32'(c_ack), 0);
      check("rst_p_ack", 32'(p_ack), 0);
    end else begin
      check("busy", 32'(busy), m_busy);
      check("wr_count", 32'(wr_count), m_wc);
      wc0 = m_wc;
      ce  = (m_busy != 0) && c_req;
      // A pool L0 read of a word not yet written this frame does not compete.
      pe  = (m_busy != 0) && p_req && !(!p_we && !p_sel && (int'(p_addr) >= m_wc));
      if (ce && pe) begin
        gc = m_last_pool;
        gp = !m_last_pool;
      end else begin
        gc = ce;
        gp = pe;
      end
      check("c_ack", 32'(c_ack), 32'(gc));
      check("p_ack", 32'(p_ack), 32'(gp));
      e.stamp = cyc; e.wr = 1'b0; e.rd = 1'b0; e.sel = 3'b000; e.addr = 12'h000; e.data = 20'h00000;
      if (gc) begin
        e.wr = 1'b1; e.sel = 3'b001; e.addr = c_addr; e.data = c_wdata;
        exp_mem[0][c_addr] = c_wdata;
        if (m_wc < 4096) m_wc = m_wc + 1;
        m_last_pool = 1'b0;
      end else if (gp) begin
        e.sel = p_sel ? 3'b011 : 3'b001;
        e.addr = p_addr;
        m_last_pool = 1'b1;
        if (p_we) begin
          e.wr = 1'b1; e.data = p_wdata;
          exp_mem[p_sel][p_addr] = p_wdata;
        end else begin
          e.rd = 1'b1;
          rd_q.push_back('{cyc + 2, exp_mem[p_sel][p_addr]});
        end
      end
      port_q.push_back(e);
      if (m_busy == 0 && start) begin
        m_busy = 1;
        m_wc   = 0;
      end else if (m_busy != 0 && p_done && wc0 == 4096) begin
        m_busy = 0;
      end
    end
  end

  // Monitor: compares port cycles and read returns against queued expectations.
  always @(negedge clk) begin : monitor
    port_t e;
    rd_t   r;
    if (!reset) begin
      port_q.delete();
      rd_q.delete();
      exp_last_rdata = 20'h00000;
      check("rst_cwr", 32'(cwr), 0);
      check("rst_crd", 32'(crd), 0);
      check("rst_csel", 32'(csel), 0);
      check("rst_p_rvalid", 32'(p_rvalid), 0);
      check("rst_p_rdata", 32'(p_rdata), 0);
      check("rst_caddr_wr", 32'(caddr_wr), 0);
      check("rst_caddr_rd", 32'(caddr_rd), 0);
      check("rst_cdata_wr", 32'(cdata_wr), 0);
    end else begin
      if (port_q.size() > 0 && port_q[0].stamp == cyc - 1) begin
        e = port_q.pop_front();
        check("cwr", 32'(cwr), 32'(e.wr));
        check("crd", 32'(crd), 32'(e.rd));
        check("csel", 32'(csel), 32'(e.sel));
        if (e.wr) begin
          check("caddr_wr", 32'(caddr_wr), 32'(e.addr));
          check("cdata_wr", 32'(cdata_wr), 32'(e.data));
        end
        if (e.rd) check("caddr_rd", 32'(caddr_rd), 32'(e.addr));
      end
      if (p_rvalid) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rvalid actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          r = rd_q.pop_front();
          check("rvalid_cycle", 32'(cyc), 32'(r.due));
          check("p_rdata", 32'(p_rdata), 32'(r.data));
          exp_last_rdata = r.data;
        end
      end else begin
        if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
          r = rd_q.pop_front();
          checks++; errors++;
          $display("FAIL missing_rvalid actual=0 expected=1 (due cycle %0d)", r.due);
        end
        check("p_rdata_hold", 32'(p_rdata), 32'(exp_last_rdata));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    c_got = c_ack;
    p_got = p_ack;
    @(posedge clk);
    #1;
    start  = 1'b0;
    p_done = 1'b0;
    if (c_got) c_req = 1'b0;
    if (p_got) p_req = 1'b0;
  endtask

  task automatic wait_c(input int lim);
    int n = 0;
    while (c_req && n < lim) begin tick(); n++; end
    checks++;
    if (c_req) begin
      errors++;
      $display("FAIL conv_ack_timeout actual=no_ack required=ack within %0d cycles", lim);
      c_req = 1'b0;
    end
  endtask

  task automatic wait_p(input int lim);
    int n = 0;
    while (p_req && n < lim) begin tick(); n++; end
    checks++;
    if (p_req) begin
      errors++;
      $display("FAIL pool_ack_timeout actual=no_ack required=ack within %0d cycles", lim);
      p_req = 1'b0;
    end
  endtask

  task automatic conv_wr(input int a, input logic [19:0] d);
    c_req = 1'b1; c_addr = 12'(a); c_wdata = d;
    wait_c(50);
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int conv_cnt;
    int lim;
    int v;
    bit early;
    for (int i = 0; i < 4096; i++) begin
      exp_mem[0][i] = init_word(1'b0, 12'(i));
      exp_mem[1][i] = init_word(1'b1, 12'(i));
    end
    exp_last_rdata = 20'h00000;
    reset = 1'b1; start = 1'b0; p_done = 1'b0;
    c_req = 1'b0; c_addr = 12'h000; c_wdata = 20'h00000;
    p_req = 1'b0; p_we = 1'b0; p_sel = 1'b0; p_addr = 12'h000; p_wdata = 20'h00000;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Four back-to-back conv writes
    start = 1'b1; tick();
    for (int i = 0; i < 4; i++) conv_wr(i, 20'h00010 + 20'(i));
    check("wc_after_4", 32'(wr_count), 4);

    // Hazard: L0 read of addr 5 waits until conv writes addr 5
    conv_wr(4, 20'h00014);
    p_req = 1'b1; p_we = 1'b0; p_sel = 1'b0; p_addr = 12'h005;
    repeat (3) tick();
    check("hazard_blocked", 32'(p_req), 1);
    c_req = 1'b1; c_addr = 12'h005; c_wdata = 20'h5A5A5;
    tick();
    check("conv_wins_over_blocked", 32'(c_got), 1);
    wait_p(10);
    repeat (2) tick();
    check("hazard_read_data", 32'(p_rdata), 32'h5A5A5);

    // Start ignored while busy
    for (int a = 6; a < 100; a++) conv_wr(a, 20'($urandom));
    check("wc_100", 32'(wr_count), 100);
    start = 1'b1; tick(); tick();
    check("start_ignored_wc", 32'(wr_count), 100);
    check("start_ignored_busy", 32'(busy), 1);

    // Random traffic to the end of the frame, including saturation
    conv_cnt = 100; lim = 0; early = 1'b0;
    while (conv_cnt < 4099 && lim < 40000) begin
      if (!c_req && $urandom_range(0, 9) < 7) begin
        c_req = 1'b1; c_addr = 12'(conv_cnt); c_wdata = 20'($urandom);
      end
      if (!p_req && $urandom_range(0, 9) < 5) begin
        p_req = 1'b1; p_we = 1'($urandom_range(0, 1)); p_sel = 1'($urandom_range(0, 1));
        p_wdata = 20'($urandom);
        if (!p_we && !p_sel) begin
          v = conv_cnt - 20 + int'($urandom_range(0, 30));
          if (v < 0) v = 0;
          if (v > 4095) v = 4095;
          p_addr = 12'(v);
        end else begin
          p_addr = 12'($urandom);
        end
      end
      if (conv_cnt == 4000 && !early) begin
        p_done = 1'b1;
        early  = 1'b1;
        tick();
        check("early_done_ignored", 32'(busy), 1);
      end else begin
        tick();
      end
      if (c_got) conv_cnt++;
      lim++;
    end
    wait_c(20);
    wait_p(20);
    check("wc_saturated", 32'(wr_count), 4096);
    p_done = 1'b1; tick();
    check("done_clears_busy", 32'(busy), 0);
    repeat (3) tick();

    // Reset in the cycle a pool read is acked
    start = 1'b1; tick();
    conv_wr(0, 20'h00001);
    conv_wr(1, 20'h00002);
    p_req = 1'b1; p_we = 1'b0; p_sel = 1'b1; p_addr = 12'h007;
    @(negedge clk);
    check("pre_reset_ack", 32'(p_ack), 1);
    #2 reset = 1'b0;
    #1;
    check("reset_busy_now", 32'(busy), 0);
    check("reset_wc_now", 32'(wr_count), 0);
    check("reset_p_ack_now", 32'(p_ack), 0);
    @(posedge clk); #1 p_req = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Restart; first tie after reset goes to conv, then alternates
    start = 1'b1; tick();
    conv_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (!c_req) begin c_req = 1'b1; c_addr = 12'(conv_cnt); c_wdata = 20'($urandom); end
      if (!p_req) begin
        p_req = 1'b1; p_we = 1'b1; p_sel = 1'b1; p_addr = 12'h010; p_wdata = 20'($urandom);
      end
      tick();
      if (c_got) conv_cnt++;
      check("rr_order", {30'd0, c_got, p_got}, (k % 2 == 0) ? 32'd2 : 32'd1);
    end
    wait_c(20);
    wait_p(20);
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
